// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer slice.
//   state_t        : FSM encoding (IDLE / RUN / FINISH, code 3 unused)
//   DEF_WIDTH      : default interval counter width
//   DEF_EXP_WIDTH  : default saturating expiry counter width
package tick_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_EXP_WIDTH = 4;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the ring-counter timebase.
//   CK   : clock shared with the ring counter
//   RST  : async active-high reset (clears the history register)
//   TICK : timebase level from the ring counter Q
//   RISE : high for the cycle in which TICK is high and was low last cycle
// Because the history register resets to 0, a TICK already high when reset
// releases is seen as one rise on the first clock.
module tick_edge_detect (
  input  logic CK,
  input  logic RST,
  input  logic TICK,
  output logic RISE
);

  logic tick_q;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) tick_q <= 1'b0;
    else     tick_q <= TICK;
  end

  assign RISE = TICK & ~tick_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable interval timer clocked by ring-counter ticks.
//   CK, RST  : clock / async active-high reset
//   TICK     : timebase level; each rising edge is one tick
//   START    : arm with LOAD_VAL (only honoured when idle)
//   STOP     : abort and return to idle (wins over everything else)
//   RELOAD   : at interval end, 1 = restart with LOAD_VAL, 0 = go idle
//   LOAD_VAL : interval length in ticks (0 = immediate expiry)
//   COUNT    : ticks remaining
//   BUSY     : high while running or finishing
//   DONE     : one-cycle pulse per completed interval
//   EXPIRIES : completed intervals since reset, saturating at all-ones
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int C_WIDTH     = DEF_WIDTH,
  parameter int C_EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   TICK,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   RELOAD,
  input  logic [C_WIDTH-1:0]     LOAD_VAL,
  output logic [C_WIDTH-1:0]     COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [C_EXP_WIDTH-1:0] EXPIRIES
);

  state_t                 state_q, state_d;
  logic [C_WIDTH-1:0]     count_q, count_d;
  logic [C_EXP_WIDTH-1:0] exp_q;
  logic                   tick_rise;
  logic                   load_zero;

  tick_edge_detect u_edge (
    .CK   (CK),
    .RST  (RST),
    .TICK (TICK),
    .RISE (tick_rise)
  );

  assign load_zero = (LOAD_VAL == '0);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (state_q == ST_FINISH && !(&exp_q))
        exp_q <= exp_q + C_EXP_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
        if (START && !STOP) begin
          count_d = LOAD_VAL;
          // a zero-length interval skips RUN but still reports DONE
          state_d = load_zero ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        // STOP takes priority over a coincident tick: count stays frozen
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (tick_rise) begin
          count_d = count_q - C_WIDTH'(1);
          if (count_q == C_WIDTH'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // ticks arriving here are dropped; with tick spacing >= 2 none is lost
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (RELOAD) begin
          count_d = LOAD_VAL;
          state_d = load_zero ? ST_FINISH : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign COUNT    = count_q;
  assign BUSY     = (state_q == ST_RUN) || (state_q == ST_FINISH);
  assign DONE     = (state_q == ST_FINISH);
  assign EXPIRIES = exp_q;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  localparam int W  = 8;
  localparam int EW = 4;
  localparam int EXP_MAX = (1 << EW) - 1;

  logic          CK = 1'b0;
  logic          RST, TICK, START, STOP, RELOAD;
  logic [W-1:0]  LOAD_VAL, COUNT;
  logic          BUSY, DONE;
  logic [EW-1:0] EXPIRIES;

  tick_timer #(.C_WIDTH(W), .C_EXP_WIDTH(EW)) dut (
    .CK(CK), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP),
    .RELOAD(RELOAD), .LOAD_VAL(LOAD_VAL), .COUNT(COUNT), .BUSY(BUSY),
    .DONE(DONE), .EXPIRIES(EXPIRIES)
  );

  always #5 CK = ~CK;

  typedef struct {
    int count;
    bit busy;
    bit done;
    int expiries;
  } snap_t;

  snap_t exp_q[$];
  int    done_times[$];
  int    n_pass = 0, n_chk = 0, cyc = 0, tph = 0;

  // Reference model: "waiting", "counting" or "signalling" an expiry.
  localparam int WAITING = 0, COUNTING = 1, SIGNALLING = 2;
  int mode = WAITING, remaining = 0, expired = 0;
  bit last_tick = 0;

  function automatic void check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
  endfunction

  function automatic snap_t model_out();
    snap_t s;
    s.count    = remaining;
    s.busy     = (mode != WAITING);
    s.done     = (mode == SIGNALLING);
    s.expiries = expired;
    return s;
  endfunction

  // Advance the model across one rising edge with the current inputs.
  function automatic void model_edge();
    bit rise;
    if (RST) begin
      mode = WAITING; remaining = 0; expired = 0; last_tick = 0;
      return;
    end
    rise = TICK && !last_tick;
    last_tick = TICK;
    if (mode == WAITING) begin
      if (START && !STOP) begin
        remaining = LOAD_VAL;
        mode = (remaining > 0) ? COUNTING : SIGNALLING;
      end
    end else if (mode == COUNTING) begin
      if (STOP) mode = WAITING;
      else if (rise) begin
        remaining = remaining - 1;
        if (remaining == 0) mode = SIGNALLING;
      end
    end else begin
      if (expired < EXP_MAX) expired = expired + 1;
      if (STOP) mode = WAITING;
      else if (RELOAD) begin
        remaining = LOAD_VAL;
        mode = (remaining > 0) ? COUNTING : SIGNALLING;
      end else mode = WAITING;
    end
  endfunction

  task automatic step(bit tick, bit start, bit stop, bit reload, int load);
    TICK = tick; START = start; STOP = stop; RELOAD = reload; LOAD_VAL = W'(load);
    model_edge();
    exp_q.push_back(model_out());
    @(posedge CK); #1;
  endtask

  // Periodic tick: high for `width` cycles out of every `period`.
  task automatic pstep(int period, int width, bit start, bit stop, bit reload, int load);
    step((tph % period) < width, start, stop, reload, load);
    tph++;
  endtask

  always @(negedge CK) begin
    snap_t s;
    cyc++;
    if (DONE) done_times.push_back(cyc);
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("count",    32'(COUNT),    s.count);
      check("busy",     32'(BUSY),     32'(s.busy));
      check("done",     32'(DONE),     32'(s.done));
      check("expiries", 32'(EXPIRIES), s.expiries);
    end
  end

  task automatic async_reset();
    snap_t r;
    RST = 1'b1;
    #1;
    check("async_rst_count", 32'(COUNT), 0);
    check("async_rst_busy",  32'(BUSY), 0);
    check("async_rst_exp",   32'(EXPIRIES), 0);
    check("async_rst_done",  32'(DONE), 0);
    model_edge();
    r = model_out();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = r;
  endtask

  initial begin
    RST = 1'b1; TICK = 0; START = 0; STOP = 0; RELOAD = 0; LOAD_VAL = '0;
    model_edge();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("reset_busy", 32'(BUSY), 0);
    check("reset_count", 32'(COUNT), 0);
    RST = 1'b0;

    // Reset mid-run: two ticks into a 5-tick interval.
    tph = 1;
    pstep(4, 1, 1, 0, 0, 5);
    for (int i = 0; i < 8; i++) pstep(4, 1, 0, 0, 0, 5);
    async_reset();
    step(0, 0, 0, 0, 5);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) pstep(4, 1, 0, 0, 0, 5);

    // Basic single interval of 3 ticks.
    tph = 1;
    pstep(4, 1, 1, 0, 0, 3);
    for (int i = 0; i < 16; i++) pstep(4, 1, 0, 0, 0, 3);

    // Periodic, 2 ticks every 4 cycles: DONE spacing must be 8 cycles.
    done_times.delete();
    tph = 1;
    pstep(4, 1, 1, 0, 1, 2);
    for (int i = 0; i < 40; i++) pstep(4, 1, 0, 0, 1, 2);
    if (done_times.size() < 5) check("periodic_done_count", done_times.size(), 5);
    else for (int i = 1; i < 5; i++)
      check("periodic_spacing", done_times[i] - done_times[i-1], 8);
    for (int i = 0; i < 10; i++) pstep(4, 1, 0, 0, 0, 2);

    // STOP and tick rise coincide with one tick remaining.
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Zero-length interval, then saturate the expiry counter.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("exp_saturated", 32'(EXPIRIES), EXP_MAX);

    // Wide tick: held high 3 of every 6 cycles counts once per period.
    tph = 3;
    pstep(6, 3, 1, 0, 0, 2);
    for (int i = 0; i < 20; i++) pstep(6, 3, 0, 0, 0, 2);

    // Tick already high across reset release.
    async_reset();
    step(1, 0, 0, 0, 0);
    RST = 1'b0;
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int p;
      p = 2 + (i / 50) % 4;
      step((i % p) == 0 || ($urandom_range(0, 9) == 0),
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 4));
    end

    step(0, 0, 1, 0, 0);
    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
